// File: rtl/u_pg_rca16_wide_seq.sv
// rtl/u_pg_rca16_wide_seq.sv - multi-cycle wide adder sequencer around a 16-bit pg ripple-carry adder
module u_pg_rca16_wide_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] in_a,
    input  logic [16*WORDS-1:0] in_b,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    input  logic [16:0]         add_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS:0]   out_sum
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W:0]       sum_q;
    logic [15:0]      word;
    logic             carry_next;
    logic             accept;
    logic             last;

    assign accept  = in_valid && in_ready;
    assign last    = (idx == IDX_LAST);
    assign out_sum = sum_q;

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake decode from the registered state only.
    // in_ready is additionally held low while rst is asserted.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slice mux to the external adder and the inter-word carry incrementer.
    // The adder's own carry and the incrementer's overflow cannot both be set:
    // add_sum[15:0]==FFFF with add_sum[16]=1 would need a 17-bit sum above 0x1FFFE.
    always_comb begin
        add_a      = 16'h0000;
        add_b      = 16'h0000;
        word       = add_sum[15:0] + {15'b0, carry};
        carry_next = add_sum[16] | (carry & (add_sum[15:0] == 16'hFFFF));
        if (state == RUN) begin
            add_a = op_a[{idx, 4'b0000} +: 16];
            add_b = op_b[{idx, 4'b0000} +: 16];
        end
    end

    // Operand capture on accept, then one result slice per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum_q <= '0;
        end else if (accept) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= in_a;
            op_b  <= in_b;
            sum_q <= '0;
        end else if (state == RUN) begin
            sum_q[{idx, 4'b0000} +: 16] <= word;
            carry                       <= carry_next;
            idx                         <= idx + 1'b1;
            if (last) begin
                sum_q[W] <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_u_pg_rca16_wide_seq.sv
// tb/tb_u_pg_rca16_wide_seq.sv - directed and throttled random bench for u_pg_rca16_wide_seq
module tb_u_pg_rca16_wide_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [16:0] add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] out_sum;

    int n_vec = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the 16-bit rca: combinational, 17-bit result, no carry-in.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    u_pg_rca16_wide_seq #(.WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair and returns once it has been accepted.
    task automatic send(input logic [63:0] a, input logic [63:0] b, output bit ok);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        ok = in_ready;
        if (ok) tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen (0 if it never rises).
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 50; c++) begin
            if (out_valid) begin
                lat = c - 1;
                break;
            end
            tick();
        end
        if (!out_valid) lat = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        repeat (2) tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 65'd0 ||
            add_a !== 16'd0 || add_b !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_sum=%h add_a=%h add_b=%h, required 0 0 0 0 0",
                     in_ready, out_valid, out_sum, add_a, add_b);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_full_carry();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        wait_valid(lat);
        n_vec++;
        if (!ok || lat != 4) begin
            n_err++;
            $display("FAIL full_carry_latency: accepted=%0d latency=%0d required 4", ok, lat);
        end
        n_vec++;
        if (out_sum !== 65'h1_0000_0000_0000_0000) begin
            n_err++;
            $display("FAIL full_carry_sum: got %h required 1_0000_0000_0000_0000", out_sum);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_carry_handoff: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_incr_carry();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(64'h0000_0000_FFFF_8000, 64'h0000_0000_0000_8000, ok);
        n_vec++;
        if (add_a !== 16'h8000 || add_b !== 16'h8000) begin
            n_err++;
            $display("FAIL incr_slice0: add_a=%h add_b=%h required 8000 8000", add_a, add_b);
        end
        tick();
        n_vec++;
        if (add_a !== 16'hFFFF || add_b !== 16'h0000) begin
            n_err++;
            $display("FAIL incr_slice1: add_a=%h add_b=%h required ffff 0000", add_a, add_b);
        end
        wait_valid(lat);
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 65'h0_0000_0001_0000_0000) begin
            n_err++;
            $display("FAIL incr_sum: out_valid=%b got %h required 0_0000_0001_0000_0000", out_valid, out_sum);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        bit ok;
        int lat;
        out_ready = 1'b0;
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0003, ok);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_sum !== 65'h1_0000_0000_0000_0003 ||
                in_ready !== 1'b0 || add_a !== 16'd0 || add_b !== 16'd0) begin
                n_err++;
                $display("FAIL back_pressure_hold[%0d]: out_valid=%b out_sum=%h in_ready=%b add_a=%h add_b=%h, required 1 1_0000_0000_0000_0003 0 0 0",
                         i, out_valid, out_sum, in_ready, add_a, add_b);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL back_pressure_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, ok);
        in_a = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b = 64'h5555_5555_5555_5555;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        wait_valid(lat);
        n_vec++;
        if (out_valid !== 1'b1 || out_sum !== 65'h0_2345_6789_ABCD_F001) begin
            n_err++;
            $display("FAIL busy_ignore_sum: got %h required 0_2345_6789_abcd_f001", out_sum);
        end
        tick();
        repeat (6) tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_ignore_no_extra: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || add_a !== 16'd0 || add_b !== 16'd0 ||
            in_ready !== 1'b0 || out_sum !== 65'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: out_valid=%b add_a=%h add_b=%h in_ready=%b out_sum=%h, required 0 0 0 0 0",
                     out_valid, add_a, add_b, in_ready, out_sum);
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        send(64'd3, 64'd4, ok);
        wait_valid(lat);
        n_vec++;
        if (!ok || lat != 4 || out_sum !== 65'd7) begin
            n_err++;
            $display("FAIL reset_recover: accepted=%0d latency=%0d got %h required latency 4 sum 7", ok, lat, out_sum);
        end
        tick();
    endtask

    task automatic test_random(input int n_ops);
        fork
            begin : producer
                logic [63:0] a;
                logic [63:0] b;
                int n;
                for (int i = 0; i < n_ops; i++) begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
                    if ($urandom_range(0, 7) == 0) b = 64'hFFFF_FFFF_FFFF_FFFF - a + 64'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 2)) tick();
                    in_a = a;
                    in_b = b;
                    in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 200) begin
                        tick();
                        n++;
                    end
                    if (!in_ready) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL random_accept_timeout: op %0d in_ready=%b required 1", i, in_ready);
                        in_valid = 1'b0;
                        break;
                    end
                    tick();
                    exp_q.push_back({1'b0, a} + {1'b0, b});
                    in_valid = 1'b0;
                end
            end
            begin : consumer
                int got;
                int cyc;
                logic [64:0] e;
                got = 0;
                cyc = 0;
                while (got < n_ops && cyc < n_ops * 40) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL random_duplicate: got %h with nothing outstanding", out_sum);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_sum !== e) begin
                                n_err++;
                                $display("FAIL random_sum[%0d]: got %h required %h", got, out_sum, e);
                            end
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                n_vec++;
                if (got != n_ops) begin
                    n_err++;
                    $display("FAIL random_count: results %0d required %0d", got, n_ops);
                end
            end
        join
        out_ready = 1'b1;
        repeat (8) tick();
        n_vec++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: out_valid=%b outstanding=%0d required 0 0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_carry();
        test_incr_carry();
        test_back_pressure();
        test_busy_ignore();
        test_reset_mid_run();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
